// File: rtl/stage_cnn_kernel_acc_pkg.sv
// Shared defaults and width helpers for the CNN kernel accumulator stage.
// Optional build macro used by the top: CNN_KERNEL_RELU_EN.
package stage_cnn_kernel_acc_pkg;

  localparam int unsigned CNN_KX  = 5;
  localparam int unsigned CNN_KY  = 5;
  localparam int unsigned CNN_IBW = 20;
  localparam int unsigned CNN_WBW = 8;
  localparam int unsigned CNN_BBW = 16;
  localparam int unsigned CNN_CH  = 3;
  localparam int unsigned CNN_OBW = 32;

  // Ceiling log2; clog2(1) == 0.
  function automatic int unsigned clog2(input int unsigned v);
    int unsigned r;
    int unsigned p;
    r = 0;
    p = 1;
    while (p < v) begin
      p = p * 2;
      r = r + 1;
    end
    return r;
  endfunction

  // Full product width.
  function automatic int unsigned cnn_mbw(input int unsigned ibw, input int unsigned wbw);
    return ibw + wbw;
  endfunction

  // Adder-tree output width for n products.
  function automatic int unsigned cnn_tbw(input int unsigned mbw, input int unsigned n);
    return mbw + clog2(n);
  endfunction

  // Channel accumulator width.
  function automatic int unsigned cnn_abw(input int unsigned tbw, input int unsigned ch);
    return tbw + clog2(ch) + 1;
  endfunction

  // Number of nodes present at a given tree level (level 0 = leaves).
  function automatic int unsigned tree_cnt(input int unsigned n, input int unsigned lvl);
    int unsigned c;
    c = n;
    for (int unsigned i = 0; i < lvl; i++) c = (c + 1) / 2;
    return c;
  endfunction

  function automatic int unsigned max3(input int unsigned a, input int unsigned b,
                                       input int unsigned c);
    int unsigned m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/cnn_adder_tree.sv
// Pipelined signed adder tree: N inputs of IW bits, one register per level,
// shared stall enable and a valid bit travelling with the data. Needs N >= 2.
module cnn_adder_tree
  import stage_cnn_kernel_acc_pkg::*;
#(
  parameter int unsigned N  = 25,
  parameter int unsigned IW = 28
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      en,
  input  logic                      in_valid,
  input  logic [N*IW-1:0]           in_data,
  output logic                      out_valid,
  output logic [IW+clog2(N)-1:0]    out_sum
);

  localparam int unsigned L  = clog2(N);
  localparam int unsigned OW = IW + L;
  localparam int unsigned HN = (N + 1) / 2;

  logic [OW-1:0] cur [L][N+1];
  logic [OW-1:0] tr  [L][HN];
  logic [L-1:0]  vld;

  // Operands of each level: sign-extended leaves, then the previous level's registers
  always_comb begin
    for (int l = 0; l < int'(L); l++)
      for (int i = 0; i <= int'(N); i++)
        cur[l][i] = '0;
    for (int i = 0; i < int'(N); i++)
      cur[0][i] = OW'($signed(in_data[i*IW +: IW]));
    for (int l = 1; l < int'(L); l++)
      for (int i = 0; i < int'(HN); i++)
        cur[l][i] = tr[l-1][i];
  end

  // One adder level per register stage; an unpaired node passes through registered
  always_ff @(posedge clk) begin
    if (en) begin
      for (int l = 0; l < int'(L); l++)
        for (int i = 0; i < int'(HN); i++)
          tr[l][i] <= cur[l][2*i] + (((2*i + 1) < int'(tree_cnt(N, l))) ? cur[l][2*i+1] : '0);
    end
  end

  // Valid pipeline matching the tree depth
  always_ff @(posedge clk) begin
    if (reset) begin
      vld <= '0;
    end else if (en) begin
      vld <= L'({vld, in_valid});
    end
  end

  assign out_valid = vld[L-1];
  assign out_sum   = tr[L-1][0];

endmodule

// File: rtl/stage_cnn_kernel_acc.sv
// KX x KY kernel MAC: parallel products, pipelined adder tree, CH-beat channel
// accumulation, bias add and saturation, valid/ready output.
// Build option: CNN_KERNEL_RELU_EN clamps negative results to zero.
module stage_cnn_kernel_acc
  import stage_cnn_kernel_acc_pkg::*;
#(
  parameter int unsigned KX  = CNN_KX,
  parameter int unsigned KY  = CNN_KY,
  parameter int unsigned IBW = CNN_IBW,
  parameter int unsigned WBW = CNN_WBW,
  parameter int unsigned BBW = CNN_BBW,
  parameter int unsigned CH  = CNN_CH,
  parameter int unsigned OBW = CNN_OBW
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   i_in_valid,
  output logic                   o_in_ready,
  input  logic [KX*KY*IBW-1:0]   i_in_fmap,
  input  logic [KX*KY*WBW-1:0]   i_cnn_weight,
  input  logic [BBW-1:0]         i_bias,
  output logic                   o_ot_valid,
  input  logic                   i_ot_ready,
  output logic [OBW-1:0]         o_ot_kernel_acc,
  output logic                   o_ot_sat
);

  localparam int unsigned N   = KX * KY;
  localparam int unsigned MBW = cnn_mbw(IBW, WBW);
  localparam int unsigned TBW = cnn_tbw(MBW, N);
  localparam int unsigned ABW = cnn_abw(TBW, CH);
  localparam int unsigned CW  = (CH > 1) ? clog2(CH) : 1;
  localparam int unsigned RBW = max3(ABW, BBW, OBW) + 1;

  localparam logic signed [RBW-1:0] SMAX = {{(RBW-OBW+1){1'b0}}, {(OBW-1){1'b1}}};
  localparam logic signed [RBW-1:0] SMIN = {{(RBW-OBW+1){1'b1}}, {(OBW-1){1'b0}}};
  localparam logic [OBW-1:0]        OMAX = {1'b0, {(OBW-1){1'b1}}};
  localparam logic [OBW-1:0]        OMIN = {1'b1, {(OBW-1){1'b0}}};

  logic                    en;
  logic [N*MBW-1:0]        prod_c;
  logic [N*MBW-1:0]        m_prod;
  logic                    m_valid;
  logic                    t_valid;
  logic [TBW-1:0]          t_sum;
  logic [CW-1:0]           ch_cnt;
  logic [ABW-1:0]          acc;
  logic                    a_valid;
  logic signed [RBW-1:0]   r_c;
  logic [OBW-1:0]          res_c;
  logic                    sat_c;

  // Whole pipeline advances unless a held result is waiting on downstream
  assign en         = !(o_ot_valid && !i_ot_ready);
  assign o_in_ready = en;

  // Full-width signed element products
  always_comb begin
    prod_c = '0;
    for (int i = 0; i < int'(N); i++)
      prod_c[i*MBW +: MBW] = MBW'($signed(i_in_fmap[i*IBW +: IBW]))
                           * MBW'($signed(i_cnn_weight[i*WBW +: WBW]));
  end

  // Stage M valid
  always_ff @(posedge clk) begin
    if (reset) begin
      m_valid <= 1'b0;
    end else if (en) begin
      m_valid <= i_in_valid;
    end
  end

  // Stage M product register
  always_ff @(posedge clk) begin
    if (en) begin
      m_prod <= prod_c;
    end
  end

  cnn_adder_tree #(
    .N  (N),
    .IW (MBW)
  ) u_tree (
    .clk       (clk),
    .reset     (reset),
    .en        (en),
    .in_valid  (m_valid),
    .in_data   (m_prod),
    .out_valid (t_valid),
    .out_sum   (t_sum)
  );

  // Stage A: accumulate CH valid tree sums; bubbles leave acc and ch_cnt alone
  always_ff @(posedge clk) begin
    if (reset) begin
      a_valid <= 1'b0;
      ch_cnt  <= '0;
      acc     <= '0;
    end else if (en) begin
      a_valid <= 1'b0;
      if (t_valid) begin
        if (ch_cnt == '0) acc <= ABW'($signed(t_sum));
        else              acc <= acc + ABW'($signed(t_sum));
        if (ch_cnt == CW'(CH - 1)) begin
          ch_cnt  <= '0;
          a_valid <= 1'b1;
        end else begin
          ch_cnt  <= ch_cnt + CW'(1);
        end
      end
    end
  end

  // Bias add, saturation and optional negative clamp
  always_comb begin
    r_c   = RBW'($signed(acc)) + RBW'($signed(i_bias));
    sat_c = 1'b0;
    res_c = OBW'(r_c);
    if (r_c > SMAX) begin
      res_c = OMAX;
      sat_c = 1'b1;
    end else if (r_c < SMIN) begin
      res_c = OMIN;
      sat_c = 1'b1;
    end
`ifdef CNN_KERNEL_RELU_EN
    if (r_c[RBW-1]) res_c = '0;
`endif
  end

  // Stage O output register, held while downstream stalls
  always_ff @(posedge clk) begin
    if (reset) begin
      o_ot_valid      <= 1'b0;
      o_ot_kernel_acc <= '0;
      o_ot_sat        <= 1'b0;
    end else if (en) begin
      o_ot_valid <= a_valid;
      if (a_valid) begin
        o_ot_kernel_acc <= res_c;
        o_ot_sat        <= sat_c;
      end
    end
  end

endmodule
